// File: rtl/mem_lsu_pkg.sv
// Shared opcodes and state encodings for the load/store unit.
// Opcode values follow the existing MEM-stage decode.
package mem_lsu_pkg;

   localparam int ALU_OP_W = 8;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
   localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
   localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
   localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
   localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
   localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
   localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
   localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering: lane select, store replication,
// load extraction/extension and misalignment detection.
module lsu_lane
   import mem_lsu_pkg::*;
(
   input  alu_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        mem,
   output logic        load,
   output logic        misalign,
   output logic [3:0]  sel,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [3:0]  bsel;
   logic [3:0]  hsel;

   // Byte address 0 is the most significant lane
   always_comb begin
      byte_v = 8'h00;
      unique case (addr_lo)
         2'd0: byte_v = rdata[31:24];
         2'd1: byte_v = rdata[23:16];
         2'd2: byte_v = rdata[15:8];
         2'd3: byte_v = rdata[7:0];
         default: byte_v = 8'h00;
      endcase
      half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
      bsel   = 4'b1000 >> addr_lo;
      hsel   = addr_lo[1] ? 4'b0011 : 4'b1100;
   end

   always_comb begin
      mem       = 1'b0;
      load      = 1'b0;
      misalign  = 1'b0;
      sel       = 4'b0000;
      wdata_rep = 32'h0;
      rdata_ext = 32'h0;
      case (op)
         EXE_LB_OP: begin
            mem       = 1'b1;
            load      = 1'b1;
            sel       = bsel;
            rdata_ext = {{24{byte_v[7]}}, byte_v};
         end
         EXE_LBU_OP: begin
            mem       = 1'b1;
            load      = 1'b1;
            sel       = bsel;
            rdata_ext = {24'h0, byte_v};
         end
         EXE_LH_OP: begin
            mem       = 1'b1;
            load      = 1'b1;
            misalign  = addr_lo[0];
            sel       = hsel;
            rdata_ext = {{16{half_v[15]}}, half_v};
         end
         EXE_LHU_OP: begin
            mem       = 1'b1;
            load      = 1'b1;
            misalign  = addr_lo[0];
            sel       = hsel;
            rdata_ext = {16'h0, half_v};
         end
         EXE_LW_OP: begin
            mem       = 1'b1;
            load      = 1'b1;
            misalign  = |addr_lo;
            sel       = 4'b1111;
            rdata_ext = rdata;
         end
         EXE_SB_OP: begin
            mem       = 1'b1;
            sel       = bsel;
            wdata_rep = {4{wdata[7:0]}};
         end
         EXE_SH_OP: begin
            mem       = 1'b1;
            misalign  = addr_lo[0];
            sel       = hsel;
            wdata_rep = {2{wdata[15:0]}};
         end
         EXE_SW_OP: begin
            mem       = 1'b1;
            misalign  = |addr_lo;
            sel       = 4'b1111;
            wdata_rep = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage with a variable-latency req/ack bus, pipeline
// stall while the access is outstanding and timeout abort.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              TIMEOUT   = 255,
   parameter logic [ADDR_W-1:0] SHARED_LO = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] SHARED_HI = 32'h8040_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  alu_op_t           aluop_i,
   input  logic [4:0]        waddr_i,
   input  logic              we_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_data_i,
   output logic [4:0]        waddr_o,
   output logic              we_o,
   output logic [31:0]       wdata_o,
   output logic              stallreq,
   output logic              shared_o,
   output logic              misalign_o,
   output logic              bus_err_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_sel_o,
   output logic [31:0]       bus_wdata_o,
   input  logic [31:0]       bus_rdata_i,
   input  logic              bus_ack_i
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   lsu_state_t        state;
   lsu_state_t        state_nxt;
   logic [15:0]       cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        sel_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              store_q;
   alu_op_t           op_q;
   logic [4:0]        waddr_q;
   logic              we_q;
   logic              err_q;

   alu_op_t     lane_op;
   logic [1:0]  lane_addr;
   logic        lane_mem;
   logic        lane_load;
   logic        lane_mis;
   logic [3:0]  lane_sel;
   logic [31:0] lane_wrep;
   logic [31:0] lane_rext;

   logic idle;
   logic launch;
   logic timeout;
   logic in_shared;

   // Idle decodes the incoming op; otherwise the latched one
   assign idle      = (state == LSU_IDLE);
   assign lane_op   = idle ? aluop_i : op_q;
   assign lane_addr = idle ? mem_addr_i[1:0] : addr_q[1:0];
   assign launch    = idle && lane_mem && !lane_mis;
   assign timeout   = (state == LSU_REQ) && !bus_ack_i
                      && (cnt == TO_LAST);
   assign in_shared = (addr_q >= SHARED_LO)
                      && (addr_q < SHARED_HI);

   lsu_lane u_lane (
      .op        (lane_op),
      .addr_lo   (lane_addr),
      .wdata     (mem_data_i),
      .rdata     (bus_rdata_i),
      .mem       (lane_mem),
      .load      (lane_load),
      .misalign  (lane_mis),
      .sel       (lane_sel),
      .wdata_rep (lane_wrep),
      .rdata_ext (lane_rext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LSU_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         LSU_IDLE: if (launch) state_nxt = LSU_REQ;
         LSU_REQ:  if (bus_ack_i || timeout) state_nxt = LSU_DONE;
         LSU_DONE: state_nxt = LSU_IDLE;
         default:  state_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 16'h0;
         addr_q  <= '0;
         sel_q   <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         store_q <= 1'b0;
         op_q    <= '0;
         waddr_q <= 5'h0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            LSU_IDLE: begin
               cnt <= 16'h0;
               if (launch) begin
                  addr_q  <= mem_addr_i;
                  sel_q   <= lane_sel;
                  wdata_q <= lane_wrep;
                  store_q <= !lane_load;
                  op_q    <= aluop_i;
                  waddr_q <= waddr_i;
                  we_q    <= we_i;
                  err_q   <= 1'b0;
                  rdata_q <= 32'h0;
               end
            end
            LSU_REQ: begin
               cnt <= cnt + 16'd1;
               if (bus_ack_i)    rdata_q <= lane_rext;
               else if (timeout) err_q   <= 1'b1;
            end
            default: cnt <= 16'h0;
         endcase
      end
   end

   // Every output is forced low while reset is held
   always_comb begin
      waddr_o     = 5'h0;
      we_o        = 1'b0;
      wdata_o     = 32'h0;
      stallreq    = 1'b0;
      shared_o    = 1'b0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_addr_o  = '0;
      bus_sel_o   = 4'h0;
      bus_wdata_o = 32'h0;
      if (!rst) begin
         unique case (state)
            LSU_IDLE: begin
               if (!lane_mem) begin
                  waddr_o = waddr_i;
                  we_o    = we_i;
                  wdata_o = wdata_i;
               end else if (lane_mis) begin
                  misalign_o = 1'b1;
               end else begin
                  stallreq = 1'b1;
               end
            end
            LSU_REQ: begin
               stallreq    = 1'b1;
               shared_o    = in_shared;
               bus_req_o   = 1'b1;
               bus_we_o    = store_q;
               bus_addr_o  = addr_q;
               bus_sel_o   = sel_q;
               bus_wdata_o = wdata_q;
               bus_err_o   = timeout;
            end
            LSU_DONE: begin
               shared_o = in_shared;
               waddr_o  = waddr_q;
               wdata_o  = rdata_q;
               we_o     = we_q && !store_q && !err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads, stores,
// misalignment, timeout and mid-access reset.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam alu_op_t NOP_OP = 8'b0010_0101;

   logic        clk;
   logic        rst;
   alu_op_t     aluop_i;
   logic [4:0]  waddr_i;
   logic        we_i;
   logic [31:0] wdata_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [4:0]  waddr_o;
   logic        we_o;
   logic [31:0] wdata_o;
   logic        stallreq;
   logic        shared_o;
   logic        misalign_o;
   logic        bus_err_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;

   int total = 0;
   int bad   = 0;

   mem_lsu #(
      .ADDR_W  (32),
      .TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .aluop_i     (aluop_i),
      .waddr_i     (waddr_i),
      .we_i        (we_i),
      .wdata_i     (wdata_i),
      .mem_addr_i  (mem_addr_i),
      .mem_data_i  (mem_data_i),
      .waddr_o     (waddr_o),
      .we_o        (we_o),
      .wdata_o     (wdata_o),
      .stallreq    (stallreq),
      .shared_o    (shared_o),
      .misalign_o  (misalign_o),
      .bus_err_o   (bus_err_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_sel_o   (bus_sel_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ack_i   (bus_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input alu_op_t op, input logic [4:0] wa,
                        input logic we, input logic [31:0] wd,
                        input logic [31:0] addr,
                        input logic [31:0] md);
      aluop_i    = op;
      waddr_i    = wa;
      we_i       = we;
      wdata_i    = wd;
      mem_addr_i = addr;
      mem_data_i = md;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(NOP_OP, 5'd4, 1'b1, 32'h5555, 32'h0, 32'h0);
      #1;
      total++;
      if (we_o !== 1'b0 || wdata_o !== 32'h0 || waddr_o !== 5'h0) begin
         bad++;
         $display("FAIL reset_wb got we=%b wd=%h wa=%h exp 0",
                  we_o, wdata_o, waddr_o);
      end
      total++;
      if (stallreq !== 1'b0 || bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl got stall=%b req=%b exp 0",
                  stallreq, bus_req_o);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      drive(NOP_OP, 5'd9, 1'b1, 32'h1234, 32'h8000_0000, 32'h0);
      @(negedge clk);
      total++;
      if (wdata_o !== 32'h1234 || we_o !== 1'b1 || waddr_o !== 5'd9) begin
         bad++;
         $display("FAIL pass_wb got wd=%h we=%b wa=%h exp 1234/1/09",
                  wdata_o, we_o, waddr_o);
      end
      total++;
      if (stallreq !== 1'b0 || bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL pass_ctl got stall=%b req=%b exp 0/0",
                  stallreq, bus_req_o);
      end
      tick();
   endtask

   task automatic test_load(input string name, input alu_op_t op,
                            input logic [31:0] exp);
      drive(op, 5'd7, 1'b1, 32'h0, 32'h8000_0001, 32'h0);
      bus_rdata_i = 32'h00F3_0000;
      for (int c = 0; c <= 4; c++) begin
         bus_ack_i = (c == 3);
         @(negedge clk);
         total++;
         if (stallreq !== (c < 4)) begin
            bad++;
            $display("FAIL %s_stall c=%0d got=%b exp=%b",
                     name, c, stallreq, c < 4);
         end
         total++;
         if (bus_req_o !== (c >= 1 && c < 4)) begin
            bad++;
            $display("FAIL %s_req c=%0d got=%b exp=%b",
                     name, c, bus_req_o, c >= 1 && c < 4);
         end
         if (c == 1) begin
            total++;
            if (bus_sel_o !== 4'b0100 || shared_o !== 1'b1
                || bus_we_o !== 1'b0 || bus_addr_o !== 32'h8000_0001) begin
               bad++;
               $display("FAIL %s_bus got sel=%b sh=%b we=%b a=%h exp 0100/1/0/80000001",
                        name, bus_sel_o, shared_o, bus_we_o, bus_addr_o);
            end
         end
         if (c == 4) begin
            total++;
            if (wdata_o !== exp || we_o !== 1'b1 || waddr_o !== 5'd7
                || shared_o !== 1'b1) begin
               bad++;
               $display("FAIL %s_wb got wd=%h we=%b wa=%h sh=%b exp %h/1/07/1",
                        name, wdata_o, we_o, waddr_o, shared_o, exp);
            end
         end
         tick();
      end
      bus_ack_i = 1'b0;
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_lw_min();
      drive(EXE_LW_OP, 5'd12, 1'b1, 32'h0, 32'h0000_0104, 32'h0);
      bus_rdata_i = 32'hDEAD_BEEF;
      tick();
      bus_ack_i = 1'b1;
      @(negedge clk);
      total++;
      if (bus_req_o !== 1'b1 || bus_sel_o !== 4'b1111 || shared_o !== 1'b0) begin
         bad++;
         $display("FAIL lw_req got req=%b sel=%b sh=%b exp 1/1111/0",
                  bus_req_o, bus_sel_o, shared_o);
      end
      tick();
      bus_ack_i = 1'b0;
      @(negedge clk);
      total++;
      if (wdata_o !== 32'hDEAD_BEEF || we_o !== 1'b1 || waddr_o !== 5'd12
          || stallreq !== 1'b0) begin
         bad++;
         $display("FAIL lw_wb got wd=%h we=%b wa=%h st=%b exp deadbeef/1/0c/0",
                  wdata_o, we_o, waddr_o, stallreq);
      end
      tick();
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_store(input string name, input alu_op_t op,
                             input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic [3:0] esel,
                             input logic [31:0] ewd);
      drive(op, 5'd2, 1'b1, 32'h0, addr, data);
      @(negedge clk);
      total++;
      if (stallreq !== 1'b1 || bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL %s_c0 got st=%b req=%b exp 1/0",
                  name, stallreq, bus_req_o);
      end
      tick();
      bus_ack_i = 1'b1;
      @(negedge clk);
      total++;
      if (bus_req_o !== 1'b1 || bus_sel_o !== esel || bus_wdata_o !== ewd
          || bus_we_o !== 1'b1 || bus_addr_o !== addr) begin
         bad++;
         $display("FAIL %s_bus got req=%b sel=%b wd=%h we=%b a=%h exp 1/%b/%h/1/%h",
                  name, bus_req_o, bus_sel_o, bus_wdata_o, bus_we_o,
                  bus_addr_o, esel, ewd, addr);
      end
      tick();
      bus_ack_i = 1'b0;
      @(negedge clk);
      total++;
      if (we_o !== 1'b0 || stallreq !== 1'b0 || bus_req_o !== 1'b0
          || bus_addr_o !== 32'h0 || bus_err_o !== 1'b0) begin
         bad++;
         $display("FAIL %s_done got we=%b st=%b req=%b a=%h err=%b exp 0",
                  name, we_o, stallreq, bus_req_o, bus_addr_o, bus_err_o);
      end
      tick();
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_misalign(input string name, input alu_op_t op,
                                input logic [31:0] addr);
      drive(op, 5'd6, 1'b1, 32'h0, addr, 32'hFFFF_FFFF);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if (misalign_o !== 1'b1 || bus_req_o !== 1'b0 || we_o !== 1'b0
             || stallreq !== 1'b0) begin
            bad++;
            $display("FAIL %s c=%0d got mis=%b req=%b we=%b st=%b exp 1/0/0/0",
                     name, c, misalign_o, bus_req_o, we_o, stallreq);
         end
         tick();
      end
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if (misalign_o !== 1'b0) begin
         bad++;
         $display("FAIL %s_clear got mis=%b exp 0", name, misalign_o);
      end
      tick();
   endtask

   task automatic test_timeout();
      int errs;
      int errc;
      errs = 0;
      errc = -1;
      drive(EXE_LW_OP, 5'd3, 1'b1, 32'h0, 32'h0000_0100, 32'h0);
      bus_ack_i = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         total++;
         if (bus_req_o !== (c >= 1 && c <= 4)) begin
            bad++;
            $display("FAIL to_req c=%0d got=%b exp=%b",
                     c, bus_req_o, c >= 1 && c <= 4);
         end
         if (bus_err_o === 1'b1) begin
            errs++;
            errc = c;
         end
         if (c == 5) begin
            total++;
            if (we_o !== 1'b0 || stallreq !== 1'b0) begin
               bad++;
               $display("FAIL to_done got we=%b st=%b exp 0/0",
                        we_o, stallreq);
            end
         end
         tick();
      end
      total++;
      if (errs !== 1 || errc !== 4) begin
         bad++;
         $display("FAIL to_err got pulses=%0d at=%0d exp 1 at 4",
                  errs, errc);
      end
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      bus_ack_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if (bus_req_o !== 1'b0 || bus_err_o !== 1'b0 || stallreq !== 1'b0
             || we_o !== 1'b0) begin
            bad++;
            $display("FAIL late_ack c=%0d got req=%b err=%b st=%b we=%b exp 0",
                     c, bus_req_o, bus_err_o, stallreq, we_o);
         end
         tick();
      end
      bus_ack_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      drive(EXE_SW_OP, 5'd1, 1'b0, 32'h0, 32'h0000_0010, 32'hCAFE_F00D);
      tick();
      @(negedge clk);
      total++;
      if (bus_req_o !== 1'b1) begin
         bad++;
         $display("FAIL rm_req got=%b exp 1", bus_req_o);
      end
      #1;
      rst = 1'b1;
      #1;
      total++;
      if (bus_req_o !== 1'b0 || stallreq !== 1'b0 || bus_err_o !== 1'b0
          || bus_addr_o !== 32'h0) begin
         bad++;
         $display("FAIL rm_async got req=%b st=%b err=%b a=%h exp 0",
                  bus_req_o, stallreq, bus_err_o, bus_addr_o);
      end
      tick();
      rst = 1'b0;
      drive(EXE_SW_OP, 5'd1, 1'b0, 32'h0, 32'h0000_0020, 32'h1122_3344);
      tick();
      bus_ack_i = 1'b1;
      @(negedge clk);
      total++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h20
          || bus_wdata_o !== 32'h1122_3344 || bus_sel_o !== 4'b1111) begin
         bad++;
         $display("FAIL rm_sw got req=%b a=%h wd=%h sel=%b exp 1/20/11223344/1111",
                  bus_req_o, bus_addr_o, bus_wdata_o, bus_sel_o);
      end
      tick();
      bus_ack_i = 1'b0;
      @(negedge clk);
      total++;
      if (stallreq !== 1'b0 || we_o !== 1'b0 || bus_err_o !== 1'b0
          || bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL rm_done got st=%b we=%b err=%b req=%b exp 0",
                  stallreq, we_o, bus_err_o, bus_req_o);
      end
      tick();
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      rst         = 1'b1;
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0;
      drive(NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_passthrough();
      test_load("lb", EXE_LB_OP, 32'hFFFF_FFF3);
      test_load("lbu", EXE_LBU_OP, 32'h0000_00F3);
      test_lw_min();
      test_store("sh", EXE_SH_OP, 32'h2, 32'hABCD_1234,
                 4'b0011, 32'h1234_1234);
      test_store("sb", EXE_SB_OP, 32'h3, 32'h0000_00A5,
                 4'b0001, 32'hA5A5_A5A5);
      test_misalign("mis_lw", EXE_LW_OP, 32'h6);
      test_misalign("mis_lh", EXE_LH_OP, 32'h3);
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
